// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory arbiter.
//   resp_owner_e : owner of the response returned in the cycle after a grant
//   RV_NOP       : instruction returned for out-of-range fetches
//   IMEM_DEPTH   : default memory depth in 32-bit words, shared with the memory array
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 256;
    localparam logic [31:0] RV_NOP     = 32'h0000_0013;

    typedef enum logic [2:0] {
        RESP_NONE   = 3'd0,
        RESP_IF     = 3'd1,
        RESP_LD     = 3'd2,
        RESP_OOR_IF = 3'd3,
        RESP_OOR_LD = 3'd4
    } resp_owner_e;

endpackage

// File: rtl/imem_starve_ctr.sv
// imem_starve_ctr: counts loader grants taken while fetch is waiting and
// forces fetch to win once STARVE_MAX such grants have happened in a row.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   if_req_i        : fetch request
//   if_gnt_i        : fetch granted this cycle
//   ld_gnt_i        : loader granted this cycle
//   fetch_force_o   : fetch must win the next conflict
module imem_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic ld_gnt_i,
    output logic fetch_force_o
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(STARVE_MAX);

    logic [CntW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (if_gnt_i || !if_req_i) begin
            starve_d = '0;
        end else if (ld_gnt_i && (starve_q != MaxCnt)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign fetch_force_o = (starve_q == MaxCnt);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port synchronous-read instruction memory
// between instruction fetch and the loader/debug port. Loader wins conflicts
// unless fetch has been starved for STARVE_MAX loader grants.
//   if_*  : fetch request/grant and read response
//   ld_*  : loader request/grant, write data and read response / write ack
//   mem_* : memory pins; mem_rdata_i is valid the cycle after mem_en_o
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH      = IMEM_DEPTH,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     if_req_i,
    input  logic [31:0]              if_addr_i,
    output logic                     if_gnt_o,
    output logic                     if_rvalid_o,
    output logic [31:0]              if_rdata_o,
    input  logic                     ld_req_i,
    input  logic                     ld_we_i,
    input  logic [31:0]              ld_addr_i,
    input  logic [31:0]              ld_wdata_i,
    output logic                     ld_gnt_o,
    output logic                     ld_rvalid_o,
    output logic [31:0]              ld_rdata_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [$clog2(DEPTH)-1:0] mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    resp_owner_e resp_q, resp_d;
    logic        we_q, we_d;
    logic        fetch_force;
    logic        if_oor, ld_oor;
    logic        unused_addr_bits;

    // Byte offset within a word is ignored.
    assign unused_addr_bits = ^{if_addr_i[1:0], ld_addr_i[1:0]};

    assign if_oor = |if_addr_i[31:AW+2];
    assign ld_oor = |ld_addr_i[31:AW+2];

    imem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .if_req_i      (if_req_i),
        .if_gnt_i      (if_gnt_o),
        .ld_gnt_i      (ld_gnt_o),
        .fetch_force_o (fetch_force)
    );

    // Grants and memory pins; everything is held at 0 while in reset.
    always_comb begin
        if_gnt_o    = rst_ni & if_req_i & (~ld_req_i | fetch_force);
        ld_gnt_o    = rst_ni & ld_req_i & ~if_gnt_o;
        mem_en_o    = (if_gnt_o & ~if_oor) | (ld_gnt_o & ~ld_oor);
        mem_we_o    = ld_gnt_o & ld_we_i & ~ld_oor;
        mem_addr_o  = '0;
        if (if_gnt_o && !if_oor) begin
            mem_addr_o = if_addr_i[AW+1:2];
        end else if (ld_gnt_o && !ld_oor) begin
            mem_addr_o = ld_addr_i[AW+1:2];
        end
        mem_wdata_o = mem_we_o ? ld_wdata_i : 32'h0;
    end

    // Owner of next cycle's response, rewritten every cycle so accesses pipeline.
    always_comb begin
        resp_d = RESP_NONE;
        if (if_gnt_o) begin
            resp_d = if_oor ? RESP_OOR_IF : RESP_IF;
        end else if (ld_gnt_o) begin
            resp_d = ld_oor ? RESP_OOR_LD : RESP_LD;
        end
        we_d = ld_gnt_o & ld_we_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_q <= RESP_NONE;
            we_q   <= 1'b0;
        end else begin
            resp_q <= resp_d;
            we_q   <= we_d;
        end
    end

    // Response routing; a response pending when reset arrives is dropped.
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = 32'h0;
        ld_rvalid_o = 1'b0;
        ld_rdata_o  = 32'h0;
        if (rst_ni) begin
            case (resp_q)
                RESP_IF: begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
                RESP_OOR_IF: begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = RV_NOP;
                end
                RESP_LD: begin
                    ld_rvalid_o = 1'b1;
                    ld_rdata_o  = we_q ? 32'h0 : mem_rdata_i;
                end
                RESP_OOR_LD: begin
                    ld_rvalid_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int unsigned DEPTH      = 256;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_gnt, ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    imem_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .ld_req_i    (ld_req),
        .ld_we_i     (ld_we),
        .ld_addr_i   (ld_addr),
        .ld_wdata_i  (ld_wdata),
        .ld_gnt_o    (ld_gnt),
        .ld_rvalid_o (ld_rvalid),
        .ld_rdata_o  (ld_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory array behind the arbiter.
    logic [31:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model: golden memory contents, loader win streak, pending response.
    logic [31:0] gold [DEPTH];
    int          m_streak;
    int          m_owner;       // 0 none, 1 fetch, 2 loader
    logic [31:0] m_data;
    initial begin
        for (int i = 0; i < DEPTH; i++) gold[i] = 32'h1000_0000 + i;
        m_streak = 0;
        m_owner  = 0;
        m_data   = 32'h0;
    end

    always @(negedge clk) begin
        logic        w_if, w_ld, e_en, e_we, oor;
        logic [31:0] a;
        int          word;
        w_if = 1'b0;
        w_ld = 1'b0;
        if (rst_n) begin
            if (if_req && ld_req) begin
                if (m_streak >= STARVE_MAX) w_if = 1'b1;
                else                        w_ld = 1'b1;
            end else if (if_req) begin
                w_if = 1'b1;
            end else if (ld_req) begin
                w_ld = 1'b1;
            end
        end
        a    = w_if ? if_addr : ld_addr;
        oor  = a >= DEPTH * 4;
        word = (a / 4) % DEPTH;
        e_en = (w_if || w_ld) && !oor;
        e_we = w_ld && ld_we && !oor;

        chk("if_gnt", {31'b0, if_gnt}, {31'b0, w_if});
        chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, w_ld});
        chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        if (e_en) chk("mem_addr", {24'b0, mem_addr}, word);
        if (e_we) chk("mem_wdata", mem_wdata, ld_wdata);
        chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, rst_n && m_owner == 1});
        chk("ld_rvalid", {31'b0, ld_rvalid}, {31'b0, rst_n && m_owner == 2});
        chk("if_rdata", if_rdata, (rst_n && m_owner == 1) ? m_data : 32'h0);
        chk("ld_rdata", ld_rdata, (rst_n && m_owner == 2) ? m_data : 32'h0);

        if (!rst_n) begin
            m_owner  = 0;
            m_streak = 0;
        end else begin
            m_owner = w_if ? 1 : (w_ld ? 2 : 0);
            if (w_if)               m_data = oor ? 32'h0000_0013 : gold[word];
            else if (w_ld && ld_we) m_data = 32'h0;
            else if (w_ld)          m_data = oor ? 32'h0 : gold[word];
            if (e_we) gold[word] = ld_wdata;
            if (!if_req || w_if) m_streak = 0;
            else if (w_ld && m_streak < STARVE_MAX) m_streak++;
        end
    end

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic ldr,
                         input logic ldwe, input logic [31:0] lda, input logic [31:0] ldwd);
        @(posedge clk);
        #1;
        if_req   = ifr;
        if_addr  = ifa;
        ld_req   = ldr;
        ld_we    = ldwe;
        ld_addr  = lda;
        ld_wdata = ldwd;
        @(negedge clk);
    endtask

    logic [31:0] pat;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;

        // Reset: requests present but nothing granted.
        drive(1, 32'h0, 1, 0, 32'h0, 0);
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);

        // Fetch-only stream.
        drive(1, 32'h0, 0, 0, 32'h0, 0);
        chk("f0_gnt", {31'b0, if_gnt}, 32'h1);
        chk("f0_addr", {24'b0, mem_addr}, 32'h0);
        drive(1, 32'h4, 0, 0, 32'h0, 0);
        chk("f1_addr", {24'b0, mem_addr}, 32'h1);
        chk("f0_data", if_rdata, 32'h1000_0000);
        drive(1, 32'h8, 0, 0, 32'h0, 0);
        chk("f2_addr", {24'b0, mem_addr}, 32'h2);
        chk("f1_data", if_rdata, 32'h1000_0001);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        chk("f2_data", if_rdata, 32'h1000_0002);

        // Loader write, then fetch it back.
        drive(0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        chk("ldw_we", {31'b0, mem_we}, 32'h1);
        chk("ldw_addr", {24'b0, mem_addr}, 32'h4);
        drive(1, 32'h10, 0, 0, 32'h0, 0);
        chk("ldw_ack", {31'b0, ld_rvalid}, 32'h1);
        chk("ldw_rdata", ld_rdata, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        chk("fetch_written", if_rdata, 32'hDEAD_BEEF);

        // Contention: fetch wins every fifth cycle.
        pat = 32'h0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h20, 1, 0, 32'h30, 0);
            pat[i] = if_gnt;
        end
        chk("contention_pattern", pat, 32'h0000_0210);
        drive(0, 32'h0, 0, 0, 32'h0, 0);

        // Out of range accesses.
        drive(1, 32'h400, 0, 0, 32'h0, 0);
        chk("oor_if_gnt", {31'b0, if_gnt}, 32'h1);
        chk("oor_if_en", {31'b0, mem_en}, 32'h0);
        drive(0, 32'h0, 1, 0, 32'h400, 0);
        chk("oor_if_nop", if_rdata, 32'h0000_0013);
        chk("oor_ld_en", {31'b0, mem_en}, 32'h0);
        drive(0, 32'h0, 1, 1, 32'h404, 32'hBAD0_BAD0);
        chk("oor_ld_rvalid", {31'b0, ld_rvalid}, 32'h1);
        chk("oor_ld_rdata", ld_rdata, 32'h0);
        chk("oor_wr_we", {31'b0, mem_we}, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        chk("oor_wr_ack", {31'b0, ld_rvalid}, 32'h1);

        // Misaligned fetch uses the word address.
        drive(1, 32'h7, 0, 0, 32'h0, 0);
        chk("mis_addr", {24'b0, mem_addr}, 32'h1);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        chk("mis_data", if_rdata, 32'h1000_0001);

        // Reset while a fetch response is pending.
        drive(1, 32'h8, 0, 0, 32'h0, 0);
        chk("mf_gnt", {31'b0, if_gnt}, 32'h1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        chk("mf_rvalid_n1", {31'b0, if_rvalid}, 32'h0);
        chk("mf_gnt_n1", {31'b0, if_gnt}, 32'h0);
        chk("mf_rdata_n1", if_rdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mf_rvalid_n2", {31'b0, if_rvalid}, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk("mf_rvalid_n3", {31'b0, if_rvalid}, 32'h0);

        // Mixed traffic, checked by the model.
        drive(0, 32'h0, 1, 0, 32'h10, 0);
        drive(1, 32'hC, 0, 0, 32'h0, 0);
        chk("mix_ld_read", ld_rdata, 32'hDEAD_BEEF);
        drive(1, 32'hC, 1, 1, 32'h14, 32'h1234_5678);
        drive(1, 32'hC, 0, 0, 32'h0, 0);
        drive(1, 32'h14, 1, 0, 32'h8, 0);
        drive(1, 32'h14, 0, 0, 32'h0, 0);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        drive(0, 32'h0, 0, 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port, synchronous-read instruction memory between the core's fetch stage and the program loader/debug port. It arbitrates requests using loader-first priority with a fetch anti-starvation counter. It drives the memory's enable/write/address/data pins and routes the one-cycle-later read data back to the winning requester. It sits between the IF stage, the loader, and the instruction memory array.

## Interface
Parameters:
- DEPTH, 256: memory depth in 32-bit words (power of two).
- STARVE_MAX, 4: consecutive loader grants allowed while fetch waits (≥1).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  32  fetch byte address (PC).
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch response valid.
- if_rdata_o  out  32  fetched instruction.
- ld_req_i  in  1  loader request.
- ld_we_i  in  1  loader write (1) / read (0).
- ld_addr_i  in  32  loader byte address.
- ld_wdata_i  in  32  loader write data.
- ld_gnt_o  out  1  loader request accepted this cycle.
- ld_rvalid_o  out  1  loader response (read data or write ack).
- ld_rdata_o  out  32  loader read data; 0 for writes.
- mem_en_o  out  1  memory access enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  $clog2(DEPTH)  word address.
- mem_wdata_o  out  32  write data.
- mem_rdata_i  in  32  read data, valid the cycle after mem_en_o.

## Operation
- Grants are combinational on the current cycle's requests. At most one grant per cycle. A requester holds its req/addr/data stable until granted.
- Priority rules:
  - Loader wins a conflict unless starve_q == STARVE_MAX, in which case fetch wins.
  - starve_q increments (saturating) on each loader grant while if_req_i is high and fetch is not granted.
  - starve_q clears on any fetch grant, or when if_req_i is low.
- Word address is addr[$clog2(DEPTH)+1:2]. addr[1:0] is ignored.
- Out of range (addr[31:$clog2(DEPTH)+2] != 0):
  - The request is granted, but mem_en_o stays low.
  - A fetch response returns NOP 32'h0000_0013.
  - A loader read returns 32'h0. A loader write is dropped but still acked.
- Response tracking: resp_q ∈ {RESP_NONE, RESP_IF, RESP_LD, RESP_OOR_IF, RESP_OOR_LD} records the owner of next cycle's response.
  - It is rewritten every cycle from the current grant, so back-to-back accesses pipeline with no bubble.
  - In RESP_IF, mem_rdata_i goes to if_rdata_o. RESP_LD behaves the same way for the loader, with rdata forced to 0 when the access was a write (we_q).
- The non-owning rdata output is 0. The rvalid outputs are one-hot or zero.
- Fetch never writes. mem_we_o = ld_gnt_o & ld_we_i & in-range.

## Timing
- Reset value of every registered output and all state: 0 / RESP_NONE. That covers if_rvalid_o, ld_rvalid_o, both rdata outputs, starve_q and we_q.
- mem_* and gnt outputs are combinational. With no request they are all 0.
- Latency: a grant in cycle N gives rvalid in cycle N+1, lasting exactly 1 cycle. Throughput is 1 access per cycle.
- Simultaneous if_req_i and ld_req_i: resolved by the priority rules above. The loser sees gnt = 0 and retries next cycle.
- Reset asserted mid-operation: the pending response is discarded, with no rvalid the following cycle, and starve_q clears. A grant issued in the reset cycle itself is suppressed: all gnt and mem_en_o are forced to 0 while rst_ni is low.
- Starvation bound: with both requesting continuously, fetch is granted at least once every STARVE_MAX+1 cycles.

## Structure
- Package imem_pkg holds:
  - the resp_owner_e enum;
  - the RV_NOP constant 32'h0000_0013;
  - the default DEPTH localparam, shared with the memory.
- Sub-module imem_starve_ctr holds the saturating counter and emits fetch_force. Everything else stays in imem_arbiter.

## Test plan
- Fetch only: if_addr 0x0, 0x4, 0x8 on consecutive cycles → if_gnt_o high each cycle, mem_addr_o 0, 1, 2, and if_rdata_o equals memory words 0–2 in cycles N+1 to N+3.
- Loader write then fetch read: ld write 0x10 = 0xDEADBEEF → ld_rvalid_o next cycle with rdata 0. Then a fetch of 0x10 → if_rdata_o = 0xDEADBEEF.
- Contention (STARVE_MAX=4, both requesting continuously) → grant pattern LD, LD, LD, LD, IF, repeating. starve_q never exceeds 4.
- Out of range: fetch at 0x400 (DEPTH=256) → mem_en_o 0 and if_rdata_o 0x00000013. A loader read of 0x400 → ld_rdata_o 0.
- Reset mid-flight: grant a fetch in cycle N and pull rst_ni low in cycle N+1 → if_rvalid_o 0 in N+1 and N+2, and all outputs stay 0 until rst_ni returns high.
- Misaligned address: fetch at 0x7 → mem_addr_o 1 and the returned data is word 1.
